// File: rtl/uart_rx_ctrl.sv
// Baud-tick generator, receiver ready gating and byte capture FIFO for uart_receiver.
// Define UART_RX_CTRL_DRAIN_EN to keep ticks running for DRAIN_TICKS after enable falls.
module uart_rx_ctrl #(
   parameter int unsigned DIV_WIDTH   = 16,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned DRAIN_TICKS = 160
) (
   input  logic                         CLKIN,
   input  logic                         RESETN,
   input  logic                         enable,
   input  logic [DIV_WIDTH-1:0]         div,
   output logic                         rx_clock_enable,
   output logic                         rx_ready,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_valid,
   output logic [7:0]                   out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow,
   input  logic                         clear_overflow
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH+1);
   localparam int unsigned DW = $clog2(DRAIN_TICKS+1);

   typedef enum logic [1:0] {OFF, RUN, DRAIN} state_t;

   state_t               state, state_nxt;
   logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
   logic [DW-1:0]        drain_cnt, drain_nxt;
   logic                 tick_nxt;
   logic                 hit;

   logic [7:0]           mem [DEPTH];
   logic [PW-1:0]        rd_ptr, wr_ptr, rd_nxt;
   logic [LW-1:0]        level_nxt;
   logic                 rx_valid_q;
   logic                 push_req, push, pop, full;
   logic                 ov_nxt, ready_nxt;
   logic [7:0]           data_nxt;

   assign hit = cnt >= div;

   // Run-state sequencing and tick divider
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      drain_nxt = drain_cnt;
      tick_nxt  = 1'b0;
      case (state)
         OFF: begin
            cnt_nxt   = '0;
            drain_nxt = '0;
            if (enable) state_nxt = RUN;
         end
         RUN: begin
            drain_nxt = '0;
            cnt_nxt   = hit ? '0 : cnt + DIV_WIDTH'(1);
            tick_nxt  = hit;
            if (!enable) begin
`ifdef UART_RX_CTRL_DRAIN_EN
               state_nxt = DRAIN;
`else
               state_nxt = OFF;
               cnt_nxt   = '0;
               tick_nxt  = 1'b0;
`endif
            end
         end
         DRAIN: begin
            cnt_nxt  = hit ? '0 : cnt + DIV_WIDTH'(1);
            tick_nxt = hit;
            if (hit) drain_nxt = drain_cnt + DW'(1);
            if (enable) begin
               state_nxt = RUN;
               drain_nxt = '0;
            end else if (hit && drain_cnt == DW'(DRAIN_TICKS-1)) begin
               state_nxt = OFF;
            end
         end
         default: state_nxt = OFF;
      endcase
   end

   // FIFO push/pop decisions and next-cycle outputs
   always_comb begin
      push_req  = rx_valid && !rx_valid_q;
      pop       = out_valid && out_ready;
      full      = level == LW'(DEPTH);
      push      = push_req && (!full || pop);
      level_nxt = level;
      if (push && !pop)      level_nxt = level + LW'(1);
      else if (pop && !push) level_nxt = level - LW'(1);
      rd_nxt    = pop ? rd_ptr + PW'(1) : rd_ptr;
      data_nxt  = (push && wr_ptr == rd_nxt) ? rx_data : mem[rd_nxt];
      ov_nxt    = overflow;
      if (clear_overflow)          ov_nxt = 1'b0;
      else if (push_req && !push)  ov_nxt = 1'b1;
      ready_nxt = (state_nxt == RUN) && (level_nxt < LW'(DEPTH));
   end

   always_ff @(posedge CLKIN or negedge RESETN) begin
      if (!RESETN) begin
         state           <= OFF;
         cnt             <= '0;
         drain_cnt       <= '0;
         rx_clock_enable <= 1'b0;
         rx_ready        <= 1'b0;
         rx_valid_q      <= 1'b0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         level           <= '0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         overflow        <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         drain_cnt       <= drain_nxt;
         rx_clock_enable <= tick_nxt;
         rx_ready        <= ready_nxt;
         rx_valid_q      <= rx_valid;
         rd_ptr          <= rd_nxt;
         level           <= level_nxt;
         out_valid       <= level_nxt != '0;
         out_data        <= data_nxt;
         overflow        <= ov_nxt;
         if (push) begin
            mem[wr_ptr] <= rx_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
      end
   end
endmodule
